mem_stage_ctrl: RTL and testbench

//  Load/store controller between the CPU memory-access stage and the data RAM
//  (mem_gen_ram wrapper). Takes one byte-addressed word request at a time.

---
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_stage_ctrl.sv | 115 +++++++++++
 tb/tb_mem_stage_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Request/response and RAM-port bundle for the memory-stage load/store controller.
// slave = the controller, master = the CPU stage plus RAM side.
interface mem_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready, ram_dout,
    output req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready, ram_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Single-outstanding word load/store controller in front of a synchronous data RAM.
// Traps misaligned/out-of-range requests and returns data or completion via valid/ready.
module mem_stage_ctrl #(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_WORDS = 16
) (
  input  logic        clka,
  input  logic        rst_n,
  mem_stage_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_din_q, ram_din_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] widx;
  logic        bad_req;

  // Full 30-bit index compare so high address bits can never alias into the RAM.
  assign widx    = {2'b00, bus.req_addr[31:2]};
  assign bad_req = (bus.req_addr[1:0] != 2'b00) || (widx >= 32'(ADDR_WORDS));

  assign bus.req_ready  = (state_q == IDLE) & rst_n;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_din    = ram_din_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          if (bad_req) begin
            state_d      = RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (bus.req_we) begin
            state_d    = WR;
            ram_we_d   = 1'b1;
            ram_addr_d = widx;
            ram_din_d  = bus.req_wdata;
          end else begin
            state_d    = RD_WAIT;
            ram_addr_d = widx;
            cnt_d      = 3'(RD_LATENCY);
          end
        end
      end
      WR: begin
        state_d      = RESP;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
      RD_WAIT: begin
        // Counter reaches zero on the edge where douta holds the addressed word.
        if (cnt_q == 3'd0) begin
          state_d      = RESP;
          resp_rdata_d = bus.ram_dout;
          resp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
        end else if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: unit 0 runs RD_LATENCY=1, unit 1 runs RD_LATENCY=3,
// each against its own behavioural RAM; results are checked against a word-array model.
module tb_mem_stage_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rv = '0, rwe = '0, rr = '0;
  logic [1:0][31:0] raddr = '0, rwd = '0;
  logic [1:0]       rdy, vld, err, we;
  logic [1:0][31:0] rdat, ra, rdin;

  int total = 0;
  int bad = 0;
  logic [31:0] ref_mem [2][16];

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int LAT = (g == 0) ? 1 : 3;
    mem_stage_if ifc ();
    logic [31:0] mem [16];
    logic [31:0] pipe [LAT];

    assign ifc.req_valid  = rv[g];
    assign ifc.req_we     = rwe[g];
    assign ifc.req_addr   = raddr[g];
    assign ifc.req_wdata  = rwd[g];
    assign ifc.resp_ready = rr[g];
    assign ifc.ram_dout   = pipe[LAT-1];
    assign rdy[g]  = ifc.req_ready;
    assign vld[g]  = ifc.resp_valid;
    assign err[g]  = ifc.resp_err;
    assign rdat[g] = ifc.resp_rdata;
    assign we[g]   = ifc.ram_we;
    assign ra[g]   = ifc.ram_addr;
    assign rdin[g] = ifc.ram_din;

    initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
    end

    // Synchronous RAM: address sampled on an edge, data out LAT edges later.
    always @(posedge clk) begin
      if (ifc.ram_we) mem[ifc.ram_addr[3:0]] <= ifc.ram_din;
      pipe[0] <= mem[ifc.ram_addr[3:0]];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    mem_stage_ctrl #(.RD_LATENCY(LAT), .ADDR_WORDS(16)) dut (
      .clka(clk), .rst_n(rst_n), .bus(ifc.slave)
    );
  end

  function automatic int latf(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  // Runs one transaction and reports what was observed; o_lat=-1 means a timeout.
  task automatic txn(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input int hold, output logic [31:0] o_rd, output logic o_err,
                     output int o_lat, output int o_wep, output logic [31:0] o_wa,
                     output logic [31:0] o_wd, output bit o_stable, output bit o_hs);
    int n;
    o_rd = '0; o_err = 1'b0; o_lat = -1; o_wep = 0; o_wa = '0; o_wd = '0;
    o_stable = 1'b1; o_hs = 1'b0;
    @(negedge clk);
    n = 0;
    while (!rdy[u] && n < 20) begin @(negedge clk); n++; end
    if (!rdy[u]) return;
    rv[u] = 1'b1; rwe[u] = w; raddr[u] = a; rwd[u] = d; rr[u] = 1'b0;
    @(posedge clk); #1;
    rv[u] = 1'b0; rwe[u] = 1'($urandom); raddr[u] = $urandom; rwd[u] = $urandom;
    n = 0;
    while (n <= 40) begin
      @(negedge clk);
      if (we[u]) begin o_wep++; o_wa = ra[u]; o_wd = rdin[u]; end
      if (vld[u]) break;
      @(posedge clk);
      n++;
    end
    if (!vld[u]) return;
    o_lat = n; o_rd = rdat[u]; o_err = err[u];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      if (!vld[u] || rdat[u] !== o_rd || err[u] !== o_err || rdy[u]) o_stable = 1'b0;
      if (we[u]) o_wep++;
    end
    rr[u] = 1'b1;
    @(posedge clk); #1;
    rr[u] = 1'b0;
    o_hs = (vld[u] === 1'b0) && (rdy[u] === 1'b1);
  endtask

  task automatic test_reset;
    #3;
    for (int u = 0; u < 2; u++) begin
      total++; if ({rdy[u], vld[u], err[u], we[u]} !== 4'b0) begin bad++;
        $display("FAIL reset_flags u%0d got=%b want=0000", u, {rdy[u], vld[u], err[u], we[u]}); end
      total++; if ({rdat[u], ra[u], rdin[u]} !== 96'b0) begin bad++;
        $display("FAIL reset_buses u%0d rdata=%h addr=%h din=%h want 0", u, rdat[u], ra[u], rdin[u]); end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (rdy !== 2'b11) begin bad++; $display("FAIL ready_after_reset got=%b want=11", rdy); end
  endtask

  task automatic test_store(input int u, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd, wa, wd; logic e; int lat, wep; bit st, hs;
    txn(u, 1'b1, a, d, 0, rd, e, lat, wep, wa, wd, st, hs);
    total++; if (lat !== 2) begin bad++; $display("FAIL store_lat u%0d got=%0d want=2", u, lat); end
    total++; if (e !== 1'b0 || rd !== 32'h0) begin bad++;
      $display("FAIL store_resp u%0d err=%b rdata=%h want 0/0", u, e, rd); end
    total++; if (wep !== 1 || wa !== (a >> 2) || wd !== d) begin bad++;
      $display("FAIL store_ram u%0d pulses=%0d addr=%h din=%h want 1/%h/%h", u, wep, wa, wd, a >> 2, d); end
    total++; if (!hs) begin bad++; $display("FAIL store_handshake u%0d got=0 want=1", u); end
    ref_mem[u][a[5:2]] = d;
  endtask

  task automatic test_load(input int u, input logic [31:0] a, input int hold);
    logic [31:0] rd, wa, wd; logic e; int lat, wep; bit st, hs;
    txn(u, 1'b0, a, 32'h0, hold, rd, e, lat, wep, wa, wd, st, hs);
    total++; if (lat !== latf(u) + 2) begin bad++;
      $display("FAIL load_lat u%0d got=%0d want=%0d", u, lat, latf(u) + 2); end
    total++; if (e !== 1'b0 || rd !== ref_mem[u][a[5:2]]) begin bad++;
      $display("FAIL load_data u%0d err=%b rdata=%h want 0/%h", u, e, rd, ref_mem[u][a[5:2]]); end
    total++; if (wep !== 0) begin bad++; $display("FAIL load_no_we u%0d pulses=%0d want=0", u, wep); end
    total++; if (!st || !hs) begin bad++;
      $display("FAIL load_hold u%0d stable=%0d handshake=%0d want 1/1", u, st, hs); end
  endtask

  task automatic test_errors;
    logic [31:0] rd, wa, wd; logic e; int lat, wep; bit st, hs;
    logic [31:0] addrs [4];
    addrs[0] = 32'h0000_0006; addrs[1] = 32'h0000_0040;
    addrs[2] = 32'h4000_0008; addrs[3] = 32'h0000_0049;
    for (int i = 0; i < 4; i++) begin
      txn(0, i[0], addrs[i], 32'hA5A5_5A5A, 2, rd, e, lat, wep, wa, wd, st, hs);
      total++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin bad++;
        $display("FAIL err_resp addr=%h lat=%0d err=%b rdata=%h want 1/1/0", addrs[i], lat, e, rd); end
      total++; if (wep !== 0 || !st || !hs) begin bad++;
        $display("FAIL err_side addr=%h pulses=%0d stable=%0d hs=%0d want 0/1/1", addrs[i], wep, st, hs); end
    end
  endtask

  task automatic test_reset_mid_store;
    int n;
    @(negedge clk);
    rv[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 32'h8; rwd[0] = 32'hCAFE_F00D; rr[0] = 1'b1;
    @(posedge clk); #2;
    rv[0] = 1'b0;
    total++; if (we[0] !== 1'b1) begin bad++; $display("FAIL mid_store_we got=%b want=1", we[0]); end
    rst_n = 1'b0;
    #1;
    total++; if ({we[0], vld[0], err[0], rdy[0]} !== 4'b0 || {rdat[0], ra[0], rdin[0]} !== 96'b0) begin bad++;
      $display("FAIL async_reset we=%b vld=%b err=%b rdy=%b rdata=%h addr=%h din=%h want all 0",
               we[0], vld[0], err[0], rdy[0], rdat[0], ra[0], rdin[0]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin @(negedge clk); if (vld[0] || we[0]) n++; end
    rr[0] = 1'b0;
    total++; if (n !== 0) begin bad++; $display("FAIL no_resp_after_reset got=%0d want=0", n); end
    test_load(0, 32'h8, 0);
  endtask

  task automatic test_random(input int u, input int cnt);
    logic [31:0] rd, wa, wd, a, d, exp_rd; logic e, exp_e; int lat, wep, kind, hold, exp_lat;
    bit st, hs, w;
    for (int i = 0; i < cnt; i++) begin
      kind = $urandom_range(0, 7);
      w = 1'($urandom);
      d = $urandom;
      if (kind < 5)       a = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      else if (kind == 5) a = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      else                a = {30'($urandom_range(16, 32'h3FFF_FFFF)), 2'b00};
      hold = $urandom_range(0, 3);
      exp_e   = (a[1:0] != 2'b00) || (a[31:2] >= 30'd16);
      exp_lat = exp_e ? 1 : (w ? 2 : latf(u) + 2);
      exp_rd  = (exp_e || w) ? 32'h0 : ref_mem[u][a[5:2]];
      txn(u, w, a, d, hold, rd, e, lat, wep, wa, wd, st, hs);
      total++; if (lat !== exp_lat || e !== exp_e || rd !== exp_rd) begin bad++;
        $display("FAIL rand_resp u%0d i=%0d we=%b addr=%h lat=%0d err=%b rdata=%h want %0d/%b/%h",
                 u, i, w, a, lat, e, rd, exp_lat, exp_e, exp_rd); end
      total++; if (wep !== ((!exp_e && w) ? 1 : 0) || (wep == 1 && (wa !== (a >> 2) || wd !== d))) begin bad++;
        $display("FAIL rand_ram u%0d i=%0d pulses=%0d addr=%h din=%h", u, i, wep, wa, wd); end
      total++; if (!st || !hs) begin bad++;
        $display("FAIL rand_hold u%0d i=%0d stable=%0d hs=%0d want 1/1", u, i, st, hs); end
      if (!exp_e && w) ref_mem[u][a[5:2]] = d;
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) for (int i = 0; i < 16; i++) ref_mem[u][i] = '0;
    test_reset();
    test_store(0, 32'h8, 32'hDEAD_BEEF);
    test_load(0, 32'h8, 0);
    test_errors();
    test_store(0, 32'h10, 32'h1234_5678);
    test_load(0, 32'h10, 5);
    test_reset_mid_store();
    test_store(1, 32'h8, 32'hDEAD_BEEF);
    test_load(1, 32'h8, 0);
    test_store(1, 32'h10, 32'h1234_5678);
    test_load(1, 32'h10, 5);
    test_random(0, 40);
    test_random(1, 40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1);
  end
endmodule
